fifo_rd_stream: RTL and testbench

- Read-side output stage of the asynchronous FIFO. Lives in the rclk domain, directly downstream of the read controller and the dual-port memory read port.
- Turns the controller's empty/pop interface and the memory's 1-cycle-latency registered read data into a valid/ready stream.
- Owns a 2-entry prefetch buffer, so the stream sustains one word per cycle despite the memory read latency.

---
 rtl/fifo_pkg.sv | 10 +
 rtl/fifo_rd_buf2.sv | 50 +++++
 rtl/fifo_rd_stream.sv | 73 +++++++
 tb/tb_fifo_rd_stream.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the async FIFO read-side output stage.
package fifo_pkg;

  localparam int unsigned DWIDTH_DEF   = 8;
  localparam int unsigned RD_BUF_DEPTH = 2;
  localparam int unsigned OCC_W        = 2;

  typedef logic [OCC_W-1:0] occ_t;

endpackage

// File: rtl/fifo_rd_buf2.sv
// Two-entry circular prefetch buffer with write/read strobes and occupancy.
module fifo_rd_buf2
  import fifo_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_wr,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic              i_rd,
  output logic [DWIDTH-1:0] o_rdata,
  output occ_t              o_occ
);

  logic [DWIDTH-1:0] r_mem [RD_BUF_DEPTH];
  logic              r_head;
  logic              r_tail;
  occ_t              r_occ;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < RD_BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_head <= 1'b0;
      r_tail <= 1'b0;
      r_occ  <= '0;
    end else if (i_clr) begin
      // Clear drops contents logically; stale storage is hidden by occ=0.
      r_head <= 1'b0;
      r_tail <= 1'b0;
      r_occ  <= '0;
    end else begin
      if (i_wr) begin
        r_mem[r_tail] <= i_wdata;
        r_tail        <= ~r_tail;
      end
      if (i_rd) begin
        r_head <= ~r_head;
      end
      r_occ <= r_occ + occ_t'(i_wr) - occ_t'(i_rd);
    end
  end

  assign o_rdata = r_mem[r_head];
  assign o_occ   = r_occ;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side stream stage: pop/inflight credit logic over a 2-entry prefetch buffer.
// Optional flush input enabled by defining FIFO_RD_STREAM_FLUSH_EN.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DWIDTH    = DWIDTH_DEF,
  parameter int unsigned BUF_DEPTH = RD_BUF_DEPTH
) (
  input  logic              rclk,
  input  logic              reset,
`ifdef FIFO_RD_STREAM_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              empty,
  output logic              pop,
  input  logic [DWIDTH-1:0] rdata,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  input  logic              out_ready
);

  localparam logic [OCC_W:0] CAP = (OCC_W+1)'(BUF_DEPTH);

  logic           r_inflight;
  occ_t           w_occ;
  logic           w_deq;
  logic           w_flush;
  logic           w_wr;
  logic [OCC_W:0] w_credit;

`ifdef FIFO_RD_STREAM_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign out_valid = (w_occ != '0);
  assign w_deq     = out_valid && out_ready;
  assign w_credit  = {1'b0, w_occ} + {{OCC_W{1'b0}}, r_inflight};

  // A pop is only issued when a slot is guaranteed free as its data returns.
  always_comb begin
    pop = 1'b0;
    if (!empty && !w_flush) begin
      pop = (w_credit < CAP) || ((w_credit == CAP) && w_deq);
    end
  end

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= pop;
    end
  end

  // Data returning from a pop issued just before a flush is discarded.
  assign w_wr = r_inflight && !w_flush;

  fifo_rd_buf2 #(
    .DWIDTH(DWIDTH)
  ) u_buf (
    .i_clk   (rclk),
    .i_rst   (reset),
    .i_clr   (w_flush),
    .i_wr    (w_wr),
    .i_wdata (rdata),
    .i_rd    (w_deq),
    .o_rdata (out_data),
    .o_occ   (w_occ)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed self-checking bench for fifo_rd_stream with a small read-controller/memory model.
module tb_fifo_rd_stream;

  localparam int unsigned DW = 8;

  logic          rclk = 1'b0;
  logic          reset = 1'b0;
  logic          empty;
  logic          pop;
  logic [DW-1:0] rdata;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
`ifdef FIFO_RD_STREAM_FLUSH_EN
  logic          flush;
`endif

  logic [DW-1:0] src [256];
  logic [7:0]    wr_ptr = '0;
  logic [7:0]    rd_ptr = '0;
  int            pop_cnt = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  fifo_rd_stream #(
    .DWIDTH(DW)
  ) dut (
    .rclk      (rclk),
    .reset     (reset),
`ifdef FIFO_RD_STREAM_FLUSH_EN
    .flush     (flush),
`endif
    .empty     (empty),
    .pop       (pop),
    .rdata     (rdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 rclk = ~rclk;

  // Controller + memory model: pointer advances on pop && !empty, data one cycle later.
  assign empty = (rd_ptr == wr_ptr);

  always @(posedge rclk or posedge reset) begin
    if (reset) begin
      rd_ptr <= wr_ptr;
      rdata  <= '0;
    end else if (pop && !empty) begin
      rdata   <= src[rd_ptr];
      rd_ptr  <= rd_ptr + 8'd1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    src[wr_ptr] = w;
    wr_ptr      = wr_ptr + 8'd1;
  endtask

  initial begin
    int base;
    int got;
    int first;
    int last;
    int k;
    int gap;

    out_ready = 1'b0;
`ifdef FIFO_RD_STREAM_FLUSH_EN
    flush = 1'b0;
`endif
    #1 reset = 1'b1;
    repeat (2) @(negedge rclk);
    reset = 1'b0;
    @(negedge rclk);
    check_eq("reset_valid", 32'(out_valid), 32'd0);
    check_eq("reset_data",  32'(out_data),  32'h0);
    check_eq("reset_pop",   32'(pop),       32'd0);

    // Single word
    base = pop_cnt;
    out_ready = 1'b1;
    push(8'hA5);
    #1 check_eq("single_pop", 32'(pop), 32'd1);
    @(negedge rclk);
    check_eq("single_pop_once", 32'(pop), 32'd0);
    check_eq("single_n1_valid", 32'(out_valid), 32'd0);
    @(negedge rclk);
    check_eq("single_valid", 32'(out_valid), 32'd1);
    check_eq("single_data",  32'(out_data),  32'hA5);
    @(negedge rclk);
    check_eq("single_deq",    32'(out_valid),  32'd0);
    check_eq("single_popcnt", 32'(pop_cnt - base), 32'd1);

    // Streaming 16 words
    base = pop_cnt;
    for (int i = 0; i < 16; i++) push(8'(i));
    got = 0; first = -1; last = -1;
    for (int c = 0; c < 24; c++) begin
      @(negedge rclk);
      if (out_valid) begin
        check_eq("stream_data", 32'(out_data), 32'(got));
        got++;
        if (first < 0) first = c;
        last = c;
      end
    end
    check_eq("stream_count", 32'(got), 32'd16);
    check_eq("stream_span",  32'(last - first + 1), 32'd16);
    check_eq("stream_pops",  32'(pop_cnt - base), 32'd16);

    // Backpressure with 5 words available
    out_ready = 1'b0;
    base = pop_cnt;
    for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
    for (int c = 0; c < 5; c++) begin
      @(negedge rclk);
      if (out_valid) check_eq("bp_hold", 32'(out_data), 32'h50);
    end
    check_eq("bp_pops",    32'(pop_cnt - base), 32'd2);
    check_eq("bp_pop_low", 32'(pop),       32'd0);
    check_eq("bp_valid",   32'(out_valid), 32'd1);
    out_ready = 1'b1;
    k = 1; gap = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge rclk);
      if (out_valid) begin
        if (k < 5) check_eq("bp_data", 32'(out_data), 32'h50 + 32'(k));
        k++;
      end else if (k < 5) begin
        gap++;
      end
    end
    check_eq("bp_delivered", 32'(k),   32'd5);
    check_eq("bp_gap",       32'(gap), 32'd0);
    check_eq("bp_total_pops", 32'(pop_cnt - base), 32'd5);

    // Empty rises while the second pop is in flight
    base = pop_cnt;
    push(8'h61);
    push(8'h62);
    #1 check_eq("race_pop", 32'(pop), 32'd1);
    got = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge rclk);
      if (out_valid) begin
        check_eq("race_data", 32'(out_data), 32'h61 + 32'(got));
        got++;
      end
    end
    check_eq("race_count",    32'(got), 32'd2);
    check_eq("race_pops",     32'(pop_cnt - base), 32'd2);
    check_eq("race_pop_idle", 32'(pop), 32'd0);

`ifdef FIFO_RD_STREAM_FLUSH_EN
    // Flush with one word buffered and one in flight
    out_ready = 1'b0;
    push(8'h20);
    push(8'h21);
    @(negedge rclk);
    @(negedge rclk);
    check_eq("fl_pre_valid", 32'(out_valid), 32'd1);
    check_eq("fl_pre_data",  32'(out_data),  32'h20);
    flush = 1'b1;
    push(8'h3C);
    #1 check_eq("fl_pop_forced", 32'(pop), 32'd0);
    @(negedge rclk);
    flush = 1'b0;
    check_eq("fl_valid", 32'(out_valid), 32'd0);
    #1 check_eq("fl_pop", 32'(pop), 32'd1);
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge rclk);
      if (out_valid && got == 0) begin
        check_eq("fl_first", 32'(out_data), 32'h3C);
        got = 1;
      end
    end
    check_eq("fl_seen", 32'(got), 32'd1);
`endif

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    push(8'h90);
    push(8'h91);
    repeat (3) @(negedge rclk);
    check_eq("rst_pre_valid", 32'(out_valid), 32'd1);
    #3 reset = 1'b1;
    #1;
    check_eq("rst_async_valid", 32'(out_valid), 32'd0);
    check_eq("rst_async_data",  32'(out_data),  32'h0);
    check_eq("rst_async_pop",   32'(pop),       32'd0);
    @(negedge rclk);
    reset = 1'b0;
    @(negedge rclk);
    check_eq("rst_post_valid", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
